// File: rtl/core_rst_pkg.sv
// Shared definitions for the core reset sequencer: state encoding,
// parameter defaults and a saturating counter helper.
`ifndef XLEN
`define XLEN 32
`endif

package core_rst_pkg;

  localparam int XLEN = `XLEN;

  localparam int HOLD_CYC_DEF = 16;
  localparam int BUS_GAP_DEF  = 4;
  localparam int QTO_DEF      = 256;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_BUS_REL,
    ST_RUN,
    ST_QUIESCE
  } rst_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/core_rst_seq_if.sv
// Core-side reset and quiesce handshake bundle. The sequencer is the
// master; the core/bus fabric it controls is the slave.
interface core_rst_seq_if;
  import core_rst_pkg::*;

  logic            quiesce_req;
  logic            quiesce_ack;
  logic            bus_rstn;
  logic            core_rstn_o;
  logic [XLEN-1:0] core_bootvec_o;

  modport master (
    output quiesce_req,
    output bus_rstn,
    output core_rstn_o,
    output core_bootvec_o,
    input  quiesce_ack
  );

  modport slave (
    input  quiesce_req,
    input  bus_rstn,
    input  core_rstn_o,
    input  core_bootvec_o,
    output quiesce_ack
  );

endinterface

// File: rtl/core_rst_seq.sv
// Core reset sequencer: holds the bus fabric and CPU core in reset until the
// run request has been stable long enough, releases the bus first and the
// core a fixed gap later, and drains outstanding traffic (with a timeout)
// before putting everything back into reset.
module core_rst_seq
  import core_rst_pkg::*;
#(
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int BUS_GAP  = BUS_GAP_DEF,
  parameter int QTO      = QTO_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  core_rstn_req,
  input  logic [XLEN-1:0]       core_bootvec_i,
  core_rst_seq_if.master        core_if,
  output logic                  qto_err,
  output logic [7:0]            rst_cnt
);

  localparam logic [7:0]  HOLD_RELOAD = 8'(HOLD_CYC - 1);
  localparam logic [7:0]  GAP_RELOAD  = 8'(BUS_GAP - 1);
  localparam logic [15:0] QTO_LAST    = 16'(QTO - 1);

  rst_state_t      state;
  logic [7:0]      cnt;
  logic [15:0]     timer;
  logic            bus_rstn_q;
  logic            core_rstn_q;
  logic            quiesce_req_q;
  logic [XLEN-1:0] bootvec_q;

  assign core_if.bus_rstn       = bus_rstn_q;
  assign core_if.core_rstn_o    = core_rstn_q;
  assign core_if.quiesce_req    = quiesce_req_q;
  assign core_if.core_bootvec_o = bootvec_q;

  // Sequencer FSM; every output is registered and changes on state transitions.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_RESET;
      cnt           <= HOLD_RELOAD;
      timer         <= 16'd0;
      bus_rstn_q    <= 1'b0;
      core_rstn_q   <= 1'b0;
      quiesce_req_q <= 1'b0;
      bootvec_q     <= '0;
      qto_err       <= 1'b0;
      rst_cnt       <= 8'd0;
    end else begin
      case (state)
        ST_RESET: begin
          bus_rstn_q    <= 1'b0;
          core_rstn_q   <= 1'b0;
          quiesce_req_q <= 1'b0;
          if (!core_rstn_req) begin
            cnt <= HOLD_RELOAD;
          end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            state      <= ST_BUS_REL;
            bus_rstn_q <= 1'b1;
            bootvec_q  <= core_bootvec_i;
            cnt        <= GAP_RELOAD;
          end
        end

        ST_BUS_REL: begin
          if (!core_rstn_req) begin
            state      <= ST_RESET;
            bus_rstn_q <= 1'b0;
            cnt        <= HOLD_RELOAD;
          end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            state       <= ST_RUN;
            core_rstn_q <= 1'b1;
            rst_cnt     <= sat_inc8(rst_cnt);
          end
        end

        ST_RUN: begin
          if (!core_rstn_req) begin
            state         <= ST_QUIESCE;
            quiesce_req_q <= 1'b1;
            timer         <= 16'd0;
          end
        end

        ST_QUIESCE: begin
          if (core_if.quiesce_ack || (timer == QTO_LAST)) begin
            state         <= ST_RESET;
            bus_rstn_q    <= 1'b0;
            core_rstn_q   <= 1'b0;
            quiesce_req_q <= 1'b0;
            cnt           <= HOLD_RELOAD;
            qto_err       <= !core_if.quiesce_ack;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        default: begin
          state <= ST_RESET;
          cnt   <= HOLD_RELOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_rst_seq.sv
// Directed bench for the core reset sequencer using default parameters
// (hold 16, bus gap 4, quiesce timeout 256).
module tb_core_rst_seq;
  import core_rst_pkg::*;

  logic                 clk;
  logic                 rstn;
  logic                 core_rstn_req;
  logic [XLEN-1:0]      core_bootvec_i;
  logic                 qto_err;
  logic [7:0]           rst_cnt;

  core_rst_seq_if cif ();

  core_rst_seq dut (
    .clk            (clk),
    .rstn           (rstn),
    .core_rstn_req  (core_rstn_req),
    .core_bootvec_i (core_bootvec_i),
    .core_if        (cif),
    .qto_err        (qto_err),
    .rst_cnt        (rst_cnt)
  );

  typedef struct {
    logic            req;
    logic [XLEN-1:0] bootvec;
    logic            exp_bus;
    logic            exp_core;
  } vec_t;

  vec_t power_on_vecs[22];

  int tests_run = 0;
  int tests_failed = 0;

  // Free-running clock, posedge at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One active edge, then move to the sampling point on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_stimulus(input logic req, input logic ack,
                                input logic [XLEN-1:0] bootvec);
    core_rstn_req   = req;
    cif.quiesce_ack = ack;
    core_bootvec_i  = bootvec;
  endtask

  task automatic check_resets(input string name, input logic bus,
                              input logic core, input logic qreq);
    check_output({name, "_bus"},  32'(cif.bus_rstn),    32'(bus));
    check_output({name, "_core"}, 32'(cif.core_rstn_o), 32'(core));
    check_output({name, "_qreq"}, 32'(cif.quiesce_req), 32'(qreq));
  endtask

  // From the first RESET edge that sees the request: bus at +16, core at +20.
  task automatic run_to_run_state(input string name);
    step_n(15);
    check_output({name, "_bus_pre"}, 32'(cif.bus_rstn), 32'd0);
    step();
    check_output({name, "_bus_rise"}, 32'(cif.bus_rstn), 32'd1);
    step_n(3);
    check_output({name, "_core_pre"}, 32'(cif.core_rstn_o), 32'd0);
    step();
    check_output({name, "_core_rise"}, 32'(cif.core_rstn_o), 32'd1);
  endtask

  // Directed scenarios, in order, each starting where the previous one ended.
  initial begin
    for (int i = 0; i < 22; i++) begin
      power_on_vecs[i].req      = 1'b1;
      power_on_vecs[i].bootvec  = 32'h8000_0000;
      power_on_vecs[i].exp_bus  = (i + 1) >= 16;
      power_on_vecs[i].exp_core = (i + 1) >= 20;
    end

    rstn = 1'b0;
    apply_stimulus(1'b1, 1'b0, 32'h8000_0000);
    #1;
    check_resets("reset", 1'b0, 1'b0, 1'b0);
    check_output("reset_bootvec", core_if_bootvec(), 32'h0);
    check_output("reset_qto", 32'(qto_err), 32'd0);
    check_output("reset_cnt", 32'(rst_cnt), 32'd0);

    // Power-on: request high from the first edge after release.
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 22; i++) begin
      apply_stimulus(power_on_vecs[i].req, 1'b0, power_on_vecs[i].bootvec);
      step();
      check_output($sformatf("pwron_bus_e%0d", i + 1), 32'(cif.bus_rstn),
                   32'(power_on_vecs[i].exp_bus));
      check_output($sformatf("pwron_core_e%0d", i + 1), 32'(cif.core_rstn_o),
                   32'(power_on_vecs[i].exp_core));
    end
    check_output("pwron_bootvec", core_if_bootvec(), 32'h8000_0000);
    check_output("pwron_cnt", 32'(rst_cnt), 32'd1);

    // Soft reset: one-cycle drop, ack arriving on the fifth quiesce cycle.
    apply_stimulus(1'b0, 1'b0, 32'h8000_0000);
    step();
    apply_stimulus(1'b1, 1'b0, 32'h2000_0000);
    check_resets("soft_entry", 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step();
      check_output($sformatf("soft_qreq_%0d", k), 32'(cif.quiesce_req), 32'd1);
    end
    check_output("soft_bootvec_hold", core_if_bootvec(), 32'h8000_0000);
    cif.quiesce_ack = 1'b1;
    step();
    cif.quiesce_ack = 1'b0;
    check_resets("soft_exit", 1'b0, 1'b0, 1'b0);
    check_output("soft_qto", 32'(qto_err), 32'd0);
    run_to_run_state("soft_rerel");
    check_output("soft_cnt", 32'(rst_cnt), 32'd2);
    check_output("soft_bootvec_new", core_if_bootvec(), 32'h2000_0000);
    core_bootvec_i = 32'hDEAD_BEEF;
    step_n(3);
    check_output("run_bootvec_hold", core_if_bootvec(), 32'h2000_0000);

    // Timeout: request drops then returns; no ack ever arrives.
    core_rstn_req = 1'b0;
    step();
    core_rstn_req = 1'b1;
    step_n(255);
    check_resets("qto_last", 1'b1, 1'b1, 1'b1);
    check_output("qto_not_yet", 32'(qto_err), 32'd0);
    step();
    check_resets("qto_exit", 1'b0, 1'b0, 1'b0);
    check_output("qto_set", 32'(qto_err), 32'd1);
    run_to_run_state("qto_rerel");
    check_output("qto_sticky", 32'(qto_err), 32'd1);
    check_output("qto_cnt", 32'(rst_cnt), 32'd3);

    // Ack already high on entry: single quiesce cycle, clears qto_err.
    apply_stimulus(1'b0, 1'b1, 32'h2000_0000);
    step();
    core_rstn_req = 1'b1;
    check_output("ackhi_qreq", 32'(cif.quiesce_req), 32'd1);
    check_output("ackhi_qto_held", 32'(qto_err), 32'd1);
    step();
    cif.quiesce_ack = 1'b0;
    check_resets("ackhi_exit", 1'b0, 1'b0, 1'b0);
    check_output("ackhi_qto_clr", 32'(qto_err), 32'd0);
    run_to_run_state("ackhi_rerel");
    check_output("ackhi_cnt", 32'(rst_cnt), 32'd4);

    // Async reset in the middle of a quiesce, checked between clock edges.
    core_rstn_req = 1'b0;
    step();
    core_rstn_req = 1'b1;
    step_n(3);
    #2;
    rstn = 1'b0;
    #1;
    check_resets("async", 1'b0, 1'b0, 1'b0);
    check_output("async_bootvec", core_if_bootvec(), 32'h0);
    check_output("async_cnt", 32'(rst_cnt), 32'd0);

    // Glitchy request: 10 high, 1 low, then high; release counts from the last rise.
    core_rstn_req = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    step_n(10);
    core_rstn_req = 1'b0;
    step();
    core_rstn_req = 1'b1;
    step_n(15);
    check_output("glitch_bus_pre", 32'(cif.bus_rstn), 32'd0);
    step();
    check_output("glitch_bus_rise", 32'(cif.bus_rstn), 32'd1);

    // Abort in BUS_REL: request sampled low two edges after bus release.
    step();
    check_resets("abort_pre", 1'b1, 1'b0, 1'b0);
    core_rstn_req = 1'b0;
    step();
    check_resets("abort_exit", 1'b0, 1'b0, 1'b0);
    step_n(4);
    check_output("abort_core_low", 32'(cif.core_rstn_o), 32'd0);
    check_output("abort_cnt", 32'(rst_cnt), 32'd0);
    core_rstn_req = 1'b1;
    run_to_run_state("abort_rerel");
    check_output("abort_rerel_cnt", 32'(rst_cnt), 32'd1);

    // Saturation: quick soft-reset sequences until the counter tops out.
    for (int n = 0; n < 255; n++) begin
      apply_stimulus(1'b0, 1'b1, 32'h2000_0000);
      step();
      core_rstn_req = 1'b1;
      step();
      cif.quiesce_ack = 1'b0;
      step_n(20);
      if (n == 253) check_output("sat_reach", 32'(rst_cnt), 32'd255);
    end
    check_output("sat_hold", 32'(rst_cnt), 32'd255);
    check_output("sat_core_run", 32'(cif.core_rstn_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  function automatic logic [31:0] core_if_bootvec();
    return 32'(cif.core_bootvec_o);
  endfunction

endmodule

// File: doc/core_rst_seq.md
CORE_RST_SEQ -- requirements
Module: core_rst_seq

Interface
REQ-001 The block SHALL have parameter HOLD_CYC, default 16: minimum cycles core_rstn_req must stay high before bus reset release (legal range 1..255).
REQ-002 The block SHALL have parameter BUS_GAP, default 4: cycles between bus_rstn release and core_rstn_o release (legal range 1..255).
REQ-003 The block SHALL have parameter QTO, default 256: quiesce timeout in cycles (legal range 1..65535).
REQ-004 The block SHALL have port clk, input, 1: sole clock.
REQ-005 The block SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-006 The block SHALL have port core_rstn_req, input, 1: core run request from the config register block (pwron & ~soft-reset); same clock domain.
REQ-007 The block SHALL have port core_bootvec_i, input, XLEN: boot vector from the config register block.
REQ-008 The block SHALL have port quiesce_ack, input, 1: core/bus idle acknowledge.
REQ-009 The block SHALL have port quiesce_req, output, 1: request to drain outstanding transactions.
REQ-010 The block SHALL have port bus_rstn, output, 1: active-low reset to the core-side bus fabric.
REQ-011 The block SHALL have port core_rstn_o, output, 1: active-low reset to the CPU core.
REQ-012 The block SHALL have port core_bootvec_o, output, XLEN: boot vector latched for the core.
REQ-013 The block SHALL have port qto_err, output, 1: sticky quiesce-timeout flag.
REQ-014 The block SHALL have port rst_cnt, output, 8: count of completed reset sequences, saturating.

Function
REQ-015 The block SHALL implement the states RESET, BUS_REL, RUN and QUIESCE; all outputs SHALL be flop outputs.
REQ-016 In RESET, bus_rstn=0, core_rstn_o=0 and quiesce_req=0; a down-counter SHALL reload to HOLD_CYC-1 on entry and on any cycle where core_rstn_req=0.
REQ-017 In RESET, on each cycle with core_rstn_req=1 and counter>0, the counter SHALL decrement; with core_rstn_req=1 and counter==0, the next state SHALL be BUS_REL.
REQ-018 bus_rstn SHALL rise exactly HOLD_CYC clock edges after the first edge that samples core_rstn_req=1 in RESET.
REQ-019 On entry to BUS_REL, core_bootvec_o SHALL capture core_bootvec_i, bus_rstn SHALL be 1, and the counter SHALL load BUS_GAP-1.
REQ-020 In BUS_REL, the counter SHALL decrement to 0, then the state SHALL go to RUN; core_rstn_o SHALL rise exactly BUS_GAP edges after bus_rstn.
REQ-021 core_rstn_req=0 sampled in BUS_REL SHALL return the state to RESET, with bus_rstn low on the next cycle; no quiesce is required.
REQ-022 In RUN, core_rstn_req=0 for any single cycle SHALL move the state to QUIESCE; a one-cycle soft-reset pulse SHALL NOT be missed.
REQ-023 In QUIESCE, quiesce_req=1 and a 16-bit timer SHALL count from 0.
REQ-024 QUIESCE SHALL exit to RESET on quiesce_ack=1, or on timer==QTO-1, which also sets qto_err.
REQ-025 If quiesce_ack is already high on entry, QUIESCE SHALL last exactly one cycle.
REQ-026 In QUIESCE, core_rstn_req returning to 1 SHALL NOT abort the sequence; the reset always completes.
REQ-027 On the QUIESCE->RESET transition, bus_rstn, core_rstn_o and quiesce_req SHALL all go to 0 in the same cycle.
REQ-028 qto_err SHALL clear only on a QUIESCE exit caused by quiesce_ack; it SHALL NOT clear on timeout or in any other state.
REQ-029 rst_cnt SHALL increment on each RUN entry and hold at 255.
REQ-030 core_bootvec_o SHALL hold its value outside BUS_REL entry; later changes to core_bootvec_i SHALL have no effect until the next sequence.

Reset
REQ-031 rstn low SHALL asynchronously force: state RESET; counter HOLD_CYC-1; timer 0; bus_rstn=0; core_rstn_o=0; quiesce_req=0; core_bootvec_o=0; qto_err=0; rst_cnt=0.
REQ-032 rstn assertion in any state, including mid-QUIESCE or mid-BUS_REL, SHALL abandon the sequence with no quiesce.

Structure
REQ-033 The state enum and the HOLD_CYC/BUS_GAP/QTO default constants SHALL live in a shared package core_rst_pkg; XLEN SHALL come from the existing global define.
REQ-034 The block SHALL be a single module; no sub-module is required.

Verification
REQ-035 Power-on: rstn release, core_rstn_req=1 from cycle 0, bootvec 0x8000_0000 -> bus_rstn high at edge 16, core_rstn_o high at edge 20, core_bootvec_o=0x8000_0000, rst_cnt=1.
REQ-036 Glitchy request: core_rstn_req high 10 cycles, low 1 cycle, high again -> bus_rstn rises 16 edges after the final rise.
REQ-037 Soft reset: in RUN, 1-cycle low pulse with quiesce_ack rising 5 cycles later -> quiesce_req high 5 cycles, all resets low next cycle, qto_err=0, re-release after 16+4 cycles, rst_cnt=2.
REQ-038 Timeout: in RUN, drop request, quiesce_ack held 0 -> reset at timer 255 (256th QUIESCE cycle), qto_err=1, and qto_err remains set through the next RUN.
REQ-039 Abort in BUS_REL: request drops 2 cycles after bus_rstn rise -> bus_rstn low next cycle, core_rstn_o never rises, rst_cnt unchanged.
REQ-040 Async reset mid-QUIESCE: rstn pulsed low -> all outputs at reset values immediately, without a clock edge.
